// File: rtl/dds_wave_gen_if.sv
// Configuration, ROM and sample bus of the DDS sample source.
// slave is the generator side; master is the config source / ROM / sample sink side.
interface dds_wave_gen_if #(
    parameter int PHASE_W = 32
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_ftw;
    logic [9:0]         cfg_poff;
    logic [1:0]         cfg_wave;
    logic [7:0]         cfg_amp;
    logic [9:0]         rom_addr;
    logic [9:0]         rom_data;
    logic               sample_valid;
    logic [9:0]         sample;

    modport slave (
        input  cfg_valid, cfg_ftw, cfg_poff, cfg_wave, cfg_amp, rom_data,
        output cfg_ready, rom_addr, sample_valid, sample
    );

    modport master (
        output cfg_valid, cfg_ftw, cfg_poff, cfg_wave, cfg_amp, rom_data,
        input  cfg_ready, rom_addr, sample_valid, sample
    );
endinterface

// File: rtl/dds_wave_gen.sv
// DDS sample source: phase accumulator, ROM addressing, wave select and amplitude
// scaling about mid-scale, with phase-continuous retuning applied on accumulator wrap.
module dds_wave_gen #(
    parameter int PHASE_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    dds_wave_gen_if.slave bus
);
    localparam int AW     = 10;
    localparam int STAGES = 3;

    typedef enum logic [1:0] {W_SINE, W_TRI, W_SAW, W_SQR} wave_e;

    typedef struct packed {
        logic [PHASE_W-1:0] ftw;
        logic [AW-1:0]      poff;
        wave_e              wave;
        logic [7:0]         amp;
    } cfg_t;

    cfg_t               act_q, act_d, shd_q, shd_d, cfg_in;
    logic               pend_q, pend_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W:0]   sum;
    logic               carry, xfer;

    logic [STAGES:1]    vld_pipe_q;
    logic [AW-1:0]      addr_q, addr_d;
    wave_e              wave1_q;
    logic [7:0]         amp1_q, amp2_q;
    logic [AW-1:0]      raw_q, raw_d;
    logic [AW-1:0]      smp_q, smp_d;
    logic signed [AW:0]   s3;
    logic signed [AW+9:0] p3;

    // Config path: immediate apply when the accumulator is idle, else park in the
    // shadow until the accumulator carries out so the phase never jumps.
    always_comb begin
        cfg_in.ftw  = bus.cfg_ftw;
        cfg_in.poff = bus.cfg_poff;
        cfg_in.wave = wave_e'(bus.cfg_wave);
        cfg_in.amp  = bus.cfg_amp;

        sum   = {1'b0, acc_q} + {1'b0, act_q.ftw};
        carry = en_i && sum[PHASE_W];
        xfer  = bus.cfg_valid && !pend_q;
        acc_d = en_i ? sum[PHASE_W-1:0] : acc_q;

        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (pend_q && carry) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end else if (xfer) begin
            if (act_q.ftw == '0 || !en_i) begin
                act_d = cfg_in;
            end else begin
                shd_d  = cfg_in;
                pend_d = 1'b1;
            end
        end
    end

    // rom_data arrives while addr_q still holds its address, so addr_q is the aligned a.
    always_comb begin
        addr_d = acc_q[PHASE_W-1 -: AW] + act_q.poff;
        unique case (wave1_q)
            W_SINE:  raw_d = bus.rom_data;
            W_TRI:   raw_d = addr_q[AW-1] ? {~addr_q[AW-2:0], 1'b0} : {addr_q[AW-2:0], 1'b0};
            W_SAW:   raw_d = addr_q;
            default: raw_d = addr_q[AW-1] ? '0 : '1;
        endcase
        s3    = $signed({1'b0, raw_q}) - 11'sd512;
        p3    = s3 * $signed({1'b0, amp2_q});
        smp_d = AW'(p3 >>> 8) + 10'd512;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            act_q      <= '0;
            shd_q      <= '0;
            pend_q     <= 1'b0;
            vld_pipe_q <= '0;
            addr_q     <= '0;
            wave1_q    <= W_SINE;
            amp1_q     <= '0;
            amp2_q     <= '0;
            raw_q      <= 10'd512;
            smp_q      <= 10'd512;
        end else begin
            acc_q      <= acc_d;
            act_q      <= act_d;
            shd_q      <= shd_d;
            pend_q     <= pend_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], en_i};
            addr_q     <= addr_d;
            wave1_q    <= act_q.wave;
            amp1_q     <= act_q.amp;
            amp2_q     <= amp1_q;
            raw_q      <= raw_d;
            if (vld_pipe_q[STAGES-1])
                smp_q <= smp_d;
        end
    end

    assign bus.cfg_ready    = !pend_q;
    assign bus.rom_addr     = addr_q;
    assign bus.sample_valid = vld_pipe_q[STAGES];
    assign bus.sample       = smp_q;
endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: stimulus pushes expected rom_addr / samples,
// a monitor pops and compares them as the DUT presents them.
module tb_dds_wave_gen;
    logic clk = 1'b0;
    logic rst;
    logic en;

    dds_wave_gen_if bus();

    dds_wave_gen dut (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Identity ROM: sine output equals the address it was read from.
    assign bus.rom_data = bus.rom_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int sq[$];
    int aq[$];

    logic [31:0] m_acc, m_ftw, s_ftw;
    int          m_poff, m_wave, m_amp, s_poff, s_wave, s_amp;
    bit          m_pend;
    bit          last_xfer;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wave_raw(input int w, input int a);
        case (w)
            0:       return a;
            1:       return (a < 512) ? 2 * a : 2 * (1023 - a);
            2:       return a;
            default: return (a < 512) ? 1023 : 0;
        endcase
    endfunction

    function automatic int exp_sample(input int raw, input int amp);
        int p, q;
        p = (raw - 512) * amp;
        q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        return 512 + q;
    endfunction

    task automatic set_cfg(input logic [31:0] ftw, input int poff, input int wave, input int amp);
        bus.cfg_ftw  = ftw;
        bus.cfg_poff = 10'(poff);
        bus.cfg_wave = 2'(wave);
        bus.cfg_amp  = 8'(amp);
    endtask

    // One clock: predict this edge from the driven inputs, then wait to the next negedge.
    task automatic step();
        int         a;
        bit         xfer, carry;
        logic [32:0] sum;
        xfer = 1'b0;
        if (rst) begin
            sq.delete();
            aq.delete();
            aq.push_back(0);
            m_acc = '0; m_ftw = '0; m_poff = 0; m_wave = 0; m_amp = 0; m_pend = 1'b0;
        end else begin
            a = (int'(m_acc[31:22]) + m_poff) % 1024;
            aq.push_back(a);
            if (en)
                sq.push_back(exp_sample(wave_raw(m_wave, a), m_amp));
            xfer  = bus.cfg_valid && !m_pend;
            sum   = {1'b0, m_acc} + {1'b0, m_ftw};
            carry = en && sum[32];
            if (en)
                m_acc = sum[31:0];
            if (m_pend && carry) begin
                m_ftw = s_ftw; m_poff = s_poff; m_wave = s_wave; m_amp = s_amp;
                m_pend = 1'b0;
            end else if (xfer) begin
                if (m_ftw == 0 || !en) begin
                    m_ftw = bus.cfg_ftw; m_poff = int'(bus.cfg_poff);
                    m_wave = int'(bus.cfg_wave); m_amp = int'(bus.cfg_amp);
                end else begin
                    s_ftw = bus.cfg_ftw; s_poff = int'(bus.cfg_poff);
                    s_wave = int'(bus.cfg_wave); s_amp = int'(bus.cfg_amp);
                    m_pend = 1'b1;
                end
            end
        end
        last_xfer = xfer;
        @(negedge clk);
    endtask

    task automatic offer_now(input logic [31:0] ftw, input int poff, input int wave, input int amp);
        bus.cfg_valid = 1'b1;
        set_cfg(ftw, poff, wave, amp);
        step();
        bus.cfg_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (aq.size() > 0)
            check("rom_addr", int'(bus.rom_addr), aq.pop_front());
        if (bus.sample_valid === 1'b1) begin
            if (sq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sample: got %0d, expected no valid sample", bus.sample);
            end else begin
                check("sample", int'(bus.sample), sq.pop_front());
            end
        end
    end

    initial begin
        bit accepted;
        rst = 1'b1;
        en  = 1'b0;
        bus.cfg_valid = 1'b0;
        set_cfg(32'd0, 0, 0, 0);
        repeat (2) step();
        check("reset_sample", int'(bus.sample), 512);
        check("reset_valid", int'(bus.sample_valid), 0);
        check("reset_ready", int'(bus.cfg_ready), 1);
        check("reset_rom_addr", int'(bus.rom_addr), 0);

        rst = 1'b0;
        en  = 1'b1;
        repeat (8) step();
        check("idle_midscale", int'(bus.sample), 512);
        check("idle_valid", int'(bus.sample_valid), 1);

        // Sawtooth, full amplitude
        en = 1'b0;
        repeat (3) step();
        check("valid_drop", int'(bus.sample_valid), 0);
        offer_now(32'h0040_0000, 0, 2, 255);
        check("ready_immediate", int'(bus.cfg_ready), 1);
        en = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            step();
            if (i == 2)    check("saw_raw0", int'(bus.sample), 2);
            if (i == 1024) check("saw_wrap_addr", int'(bus.rom_addr), 0);
            if (i == 1025) check("saw_raw1023", int'(bus.sample), 1021);
        end

        // Square, half amplitude; accumulator resumes at address 6
        en = 1'b0;
        repeat (3) step();
        offer_now(32'h0040_0000, 0, 3, 128);
        en = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            step();
            if (i == 2)   check("square_low_half", int'(bus.sample), 767);
            if (i == 508) check("square_high_half", int'(bus.sample), 256);
        end
        en = 1'b0;
        repeat (3) step();
        offer_now(32'h0040_0000, 0, 3, 0);
        en = 1'b1;
        repeat (10) step();
        check("square_amp0", int'(bus.sample), 512);

        // Sine through identity ROM with phase offset 1000
        en  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        offer_now(32'h0040_0000, 1000, 0, 255);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0)  check("sine_addr_first", int'(bus.rom_addr), 1000);
            if (i == 2)  check("sine_sample_1000", int'(bus.sample), 998);
            if (i == 23) check("sine_addr_1023", int'(bus.rom_addr), 1023);
            if (i == 24) check("sine_addr_wrap", int'(bus.rom_addr), 0);
            if (i == 25) check("sine_sample_1023", int'(bus.sample), 1021);
        end

        // Retune mid-stream
        en  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        offer_now(32'h0040_0000, 0, 2, 255);
        en = 1'b1;
        repeat (100) step();
        offer_now(32'h0080_0000, 0, 2, 255);
        check("retune_pending", int'(bus.cfg_ready), 0);
        bus.cfg_valid = 1'b1;
        set_cfg(32'h0100_0000, 0, 2, 200);
        accepted = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 10) check("ready_held_low", int'(bus.cfg_ready), 0);
            if (last_xfer) begin
                accepted = 1'b1;
                break;
            end
            if (!m_pend) check("ready_after_wrap", int'(bus.cfg_ready), 1);
        end
        bus.cfg_valid = 1'b0;
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL second_cfg_timeout: got no acceptance, expected acceptance within 3000 clk");
        end
        check("second_cfg_pending", int'(bus.cfg_ready), 0);
        repeat (600) step();
        check("second_cfg_applied", int'(bus.cfg_ready), 1);

        // Pending config discarded by reset
        offer_now(32'h0010_0000, 5, 1, 100);
        check("pend_before_rst", int'(bus.cfg_ready), 0);
        bus.cfg_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
        check("ready_after_rst", int'(bus.cfg_ready), 1);
        repeat (6) step();
        check("rst_ftw_zero_addr", int'(bus.rom_addr), 0);
        check("rst_midscale", int'(bus.sample), 512);
        check("rst_ready_stays", int'(bus.cfg_ready), 1);

        en = 1'b0;
        repeat (4) step();
        check("queue_drained", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
